// File: rtl/div_man_pkg.sv
// Shared definitions for the iterative restoring mantissa divider.
package div_man_pkg;

  // Default operand mantissa width (hidden bit included) and quotient width.
  localparam int DIV_OP_W = 12;
  localparam int DIV_Q_W  = 16;

  // Saturated quotient returned on divide-by-zero and overflow.
  localparam logic [DIV_Q_W-1:0] QUOT_SAT = {DIV_Q_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_man_step.sv
// One combinational restoring-division step: subtract if possible, then shift.
module div_man_step #(
  parameter int OP_W = 12
) (
  input  logic [OP_W:0]   rem,
  input  logic [OP_W-1:0] div,
  output logic [OP_W:0]   next_rem,
  output logic            q_bit
);

  logic [OP_W:0] diff;

  // Trial subtraction; the caller keeps rem < 2*div so the shift never drops a set bit.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    q_bit    = (rem >= {1'b0, div});
    diff     = q_bit ? (rem - {1'b0, div}) : rem;
    next_rem = diff << 1;
  end

endmodule

// File: rtl/div_man_ctrl.sv
// Iterative restoring mantissa divider: quot = floor(op1 * 2^(Q_W-1) / op2),
// with sticky, divide-by-zero and overflow flags, valid/ready on both sides.
module div_man_ctrl
  import div_man_pkg::*;
#(
  parameter int OP_W = DIV_OP_W,
  parameter int Q_W  = DIV_Q_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op1,
  input  logic [OP_W-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Q_W-1:0]  quot,
  output logic            sticky,
  output logic            div_zero,
  output logic            ovf
);

  localparam int CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Q_W - 1);

  state_t          state, state_nxt;
  logic [OP_W:0]   rem;
  logic [OP_W-1:0] div;
  logic [CNT_W-1:0] counter;

  logic            accept;
  logic            op_zero;
  logic            op_ovf;
  logic [OP_W:0]   step_rem;
  logic            step_bit;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign op_zero  = (op2 == '0);
  // Quotient fits only if op1 < 2*op2; compared at OP_W+1 bits so 2*op2 cannot wrap.
  assign op_ovf   = ({1'b0, op1} >= {op2, 1'b0});

  div_man_step #(.OP_W(OP_W)) u_step (
    .rem      (rem),
    .div      (div),
    .next_rem (step_rem),
    .q_bit    (step_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: zero/overflow short-circuit straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (op_zero || op_ovf) ? DONE : CALC;
      CALC: if (counter == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring step per CALC cycle, result hold in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem       <= '0;
      div       <= '0;
      counter   <= '0;
      quot      <= '0;
      sticky    <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_zero) begin
              div_zero  <= 1'b1;
              ovf       <= 1'b0;
              sticky    <= 1'b0;
              quot      <= QUOT_SAT;
              out_valid <= 1'b1;
            end else if (op_ovf) begin
              div_zero  <= 1'b0;
              ovf       <= 1'b1;
              sticky    <= 1'b1;
              quot      <= QUOT_SAT;
              out_valid <= 1'b1;
            end else begin
              rem     <= {1'b0, op1};
              div     <= op2;
              quot    <= '0;
              counter <= CNT_LAST;
            end
          end
        end
        CALC: begin
          rem  <= step_rem;
          quot <= {quot[Q_W-2:0], step_bit};
          if (counter == '0) begin
            sticky    <= (step_rem != '0);
            out_valid <= 1'b1;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sticky    <= 1'b0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule
